// File: rtl/seg_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_frame_arbiter_pkg
//  Description : Shared constants, scan-state encoding and digit-select
//                table for the seven-segment frame arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_frame_arbiter_pkg;

    // All segments off (segments are active low, bit7 = dp)
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    // All digit enables off (enables are active low)
    localparam logic [3:0] DIG_OFF   = 4'b1111;

    // Per-slot scan phase: lit digit, then anti-ghost blank interval
    typedef enum logic [0:0] {
        SCAN_SHOW  = 1'b0,
        SCAN_BLANK = 1'b1
    } scan_state_e;

    // One-cold digit enable for digit index 0..3 (bit0 = rightmost digit)
    function automatic logic [3:0] dig_sel(input logic [1:0] idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = 4'b1110;
            2'd1:    sel = 4'b1101;
            2'd2:    sel = 4'b1011;
            2'd3:    sel = 4'b0111;
            default: sel = DIG_OFF;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_frame_arbiter_if
//  Description : Keyboard and message valid/ready channels feeding the
//                seven-segment frame arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_frame_arbiter_if;

    logic        i_kb_valid;
    logic        o_kb_ready;
    logic [7:0]  i_kb_char;
    logic        i_kb_bksp;
    logic        i_msg_valid;
    logic        o_msg_ready;
    logic [31:0] i_msg_frame;

    // Producer side (PS/2 decode stage, message source)
    modport master (
        output i_kb_valid, i_kb_char, i_kb_bksp, i_msg_valid, i_msg_frame,
        input  o_kb_ready, o_msg_ready
    );

    // Arbiter side
    modport slave (
        input  i_kb_valid, i_kb_char, i_kb_bksp, i_msg_valid, i_msg_frame,
        output o_kb_ready, o_msg_ready
    );

endinterface
`default_nettype wire

// File: rtl/seg_frame_arbiter_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg_frame_arbiter_scan_timer
//  Description : Digit scan timing. Each digit slot is PRESCALE cycles:
//                SHOW for PRESCALE-BLANK_CYCLES, then BLANK_CYCLES with all
//                digits off. Digits cycle 0..3; o_frame_tick pulses on the
//                last cycle of the digit3 blank interval.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_frame_arbiter_scan_timer
    import seg_frame_arbiter_pkg::*;
#(
    parameter int PRESCALE     = 65536,
    parameter int BLANK_CYCLES = 4
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst_n,
    output scan_state_e o_state,
    output logic [1:0]  o_digit,
    output logic        o_frame_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_show_last  = CW'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);

    scan_state_e r_state;
    scan_state_e w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_digit;
    logic [1:0]    w_digit_nxt;
    logic          w_tick;

    // Scan state register: reset parks the scan at the start of digit0 SHOW
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SCAN_SHOW;
            r_cnt   <= '0;
            r_digit <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    // Next-state: count out SHOW, then BLANK, then advance to the next digit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_digit_nxt = r_digit;
        w_tick      = 1'b0;
        case (r_state)
            SCAN_SHOW: begin
                if (r_cnt == c_show_last) begin
                    w_state_nxt = SCAN_BLANK;
                    w_cnt_nxt   = '0;
                end
            end
            SCAN_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nxt = SCAN_SHOW;
                    w_cnt_nxt   = '0;
                    w_digit_nxt = r_digit + 2'd1;
                    w_tick      = (r_digit == 2'd3);
                end
            end
            default: begin
                w_state_nxt = SCAN_SHOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_state      = r_state;
    assign o_digit      = r_digit;
    assign o_frame_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/seg_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seg_frame_arbiter
//  Description : Owns the 4-digit seven-segment display. Keeps a persistent
//                keyboard text buffer and overlays whole-frame messages for
//                HOLD_FRAMES full scan frames. The displayed frame is
//                snapshotted at frame start so a write never tears a frame.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_frame_arbiter
    import seg_frame_arbiter_pkg::*;
#(
    parameter int PRESCALE     = 65536,
    parameter int BLANK_CYCLES = 4,
    parameter int HOLD_FRAMES  = 250,
    parameter int KB_LOCK      = 0
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    seg_frame_arbiter_if.slave io_bus,
    output logic             o_msg_active,
    output logic [3:0]       o_Chosen_Segment,
    output logic [7:0]       o_SevenSegmentDisplay
);

    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    scan_state_e w_state;
    logic [1:0]  w_digit;
    logic        w_tick;

    logic [31:0]   r_buf;
    logic [31:0]   r_msg;
    logic [31:0]   r_snap;
    logic [HW-1:0] r_hold;
    logic          r_first;
    logic          r_active;
    logic          r_kb_ready;
    logic          r_msg_ready;
    logic [3:0]    r_chosen;
    logic [7:0]    r_segs;

    logic          w_kb_xfer;
    logic          w_msg_xfer;
    logic          w_expire;
    logic          w_active_nxt;
    logic [7:0]    w_snap_byte;

    seg_frame_arbiter_scan_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_state      (w_state),
        .o_digit      (w_digit),
        .o_frame_tick (w_tick)
    );

    assign w_kb_xfer  = io_bus.i_kb_valid  && r_kb_ready;
    assign w_msg_xfer = io_bus.i_msg_valid && r_msg_ready;
    // Last message frame ends on this tick (the arming tick never counts)
    assign w_expire   = w_tick && r_active && !r_first && (r_hold == HW'(1));

    // Ownership after this edge; a fresh accept always wins over expiry
    always_comb begin
        w_active_nxt = r_active;
        if (w_msg_xfer) begin
            w_active_nxt = 1'b1;
        end else if (w_expire) begin
            w_active_nxt = 1'b0;
        end
    end

    // Keyboard text buffer: shift in from the right, backspace shifts back
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf <= 32'hFFFF_FFFF;
        end else if (w_kb_xfer) begin
            if (io_bus.i_kb_bksp) begin
                r_buf <= {SEG_BLANK, r_buf[31:8]};
            end else begin
                r_buf <= {r_buf[23:0], io_bus.i_kb_char};
            end
        end
    end

    // Message register and frame hold counter; the first tick after an
    // accept only finishes the keyboard frame already on screen
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_msg    <= 32'hFFFF_FFFF;
            r_hold   <= '0;
            r_first  <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            if (w_msg_xfer) begin
                r_msg   <= io_bus.i_msg_frame;
                r_hold  <= HW'(HOLD_FRAMES);
                r_first <= 1'b1;
            end else if (w_tick && r_active) begin
                if (r_first) begin
                    r_first <= 1'b0;
                end else begin
                    r_hold <= r_hold - HW'(1);
                end
            end
        end
    end

    // Registered readies track the ownership state after each edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kb_ready  <= 1'b0;
            r_msg_ready <= 1'b0;
        end else begin
            r_kb_ready  <= !((KB_LOCK != 0) && w_active_nxt);
            r_msg_ready <= !w_active_nxt;
        end
    end

    // Frame snapshot, reloaded only at frame start so frames never tear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_snap <= 32'hFFFF_FFFF;
        end else if (w_tick) begin
            r_snap <= (r_active && !w_expire) ? r_msg : r_buf;
        end
    end

    // Byte of the snapshot belonging to the digit being scanned
    always_comb begin
        w_snap_byte = SEG_BLANK;
        case (w_digit)
            2'd0:    w_snap_byte = r_snap[7:0];
            2'd1:    w_snap_byte = r_snap[15:8];
            2'd2:    w_snap_byte = r_snap[23:16];
            2'd3:    w_snap_byte = r_snap[31:24];
            default: w_snap_byte = SEG_BLANK;
        endcase
    end

    // Output pins are registered; blank interval forces everything off
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chosen <= DIG_OFF;
            r_segs   <= SEG_BLANK;
        end else if (w_state == SCAN_SHOW) begin
            r_chosen <= dig_sel(w_digit);
            r_segs   <= w_snap_byte;
        end else begin
            r_chosen <= DIG_OFF;
            r_segs   <= SEG_BLANK;
        end
    end

    assign io_bus.o_kb_ready     = r_kb_ready;
    assign io_bus.o_msg_ready    = r_msg_ready;
    assign o_msg_active          = r_active;
    assign o_Chosen_Segment      = r_chosen;
    assign o_SevenSegmentDisplay = r_segs;

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_frame_arbiter
//  Description : Randomized self-checking bench. A frame-level reference
//                model predicts every displayed frame and the handshake
//                state; a monitor decodes the scanned pins back into frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_frame_arbiter;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int HOLD     = 2;
    localparam int SHOW_LEN = PRESCALE - BLANK;
    localparam int FRAME    = 4 * PRESCALE;
    localparam int BUDGET   = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_frame_arbiter_if bus ();
    seg_frame_arbiter_if bus_lk ();

    logic       act, act_lk;
    logic [3:0] ch, ch_lk;
    logic [7:0] sg, sg_lk;

    seg_frame_arbiter #(
        .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK), .HOLD_FRAMES(HOLD), .KB_LOCK(0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus),
        .o_msg_active(act), .o_Chosen_Segment(ch), .o_SevenSegmentDisplay(sg)
    );

    seg_frame_arbiter #(
        .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK), .HOLD_FRAMES(HOLD), .KB_LOCK(1)
    ) dut_lk (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_lk),
        .o_msg_active(act_lk), .o_Chosen_Segment(ch_lk), .o_SevenSegmentDisplay(sg_lk)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    endtask

    task automatic fail_note(input string name, input logic [31:0] got);
        n_total++;
        $display("FAIL %s: got %h required event within budget at %0t", name, got, $time);
    endtask

    // ---------------- reference model (frame granularity) ----------------
    int          m_e    = 0;
    logic [31:0] m_buf  = '1;
    logic [31:0] m_msg  = '1;
    bit          m_act  = 0;
    int          m_left = 0;
    bit          m_kbr  = 0;
    bit          m_msgr = 0;
    logic [31:0] exp_q[$];

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_e = 0; m_buf = '1; m_act = 0; m_left = 0;
                m_kbr = 0; m_msgr = 0;
                exp_q.delete();
                exp_q.push_back(32'hFFFF_FFFF);
            end else begin
                bit kx, mx;
                kx = bus.i_kb_valid && m_kbr;
                mx = bus.i_msg_valid && m_msgr;
                m_e++;
                if (m_e % FRAME == 0) begin
                    if (m_act && m_left == 0) begin
                        m_act = 0;
                        exp_q.push_back(m_buf);
                    end else if (m_act) begin
                        exp_q.push_back(m_msg);
                        m_left--;
                    end else begin
                        exp_q.push_back(m_buf);
                    end
                end
                if (kx) m_buf = bus.i_kb_bksp ? {8'hFF, m_buf[31:8]} : {m_buf[23:0], bus.i_kb_char};
                if (mx) begin m_msg = bus.i_msg_frame; m_act = 1; m_left = HOLD; end
                m_kbr  = 1;
                m_msgr = !m_act;
            end
        end
    end

    // ---------------- monitor: decode pins into frames ----------------
    bit          synced = 0;
    int          run_len = 0;
    logic [3:0]  run_ch = 4'b1111;
    logic [7:0]  run_seg = 8'hFF;
    bit          seg_bad = 0;
    int          exp_d = 0;
    logic [31:0] frame_acc = '1;
    int          frames_seen = 0;

    task automatic close_run();
        logic [3:0]  one;
        logic [31:0] e;
        if (run_ch == 4'b1111) begin
            check("blank_len", run_len, BLANK);
            check("blank_segs", {23'd0, seg_bad, run_seg}, {23'd0, 1'b0, 8'hFF});
        end else begin
            one = 4'b0001;
            one = ~(one << exp_d);
            check("slot_digit", {28'd0, run_ch}, {28'd0, one});
            check("slot_len", run_len, SHOW_LEN);
            check("slot_steady", {31'd0, seg_bad}, 32'd0);
            frame_acc[8*exp_d +: 8] = run_seg;
            if (exp_d == 3) begin
                if (exp_q.size() == 0) begin
                    fail_note("frame_unexpected", frame_acc);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", frame_acc, e);
                    frames_seen++;
                end
            end
            exp_d = (exp_d + 1) % 4;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                synced = 0;
                exp_d  = 0;
            end else begin
                check("kb_ready", {31'd0, bus.o_kb_ready}, {31'd0, m_kbr});
                check("msg_ready", {31'd0, bus.o_msg_ready}, {31'd0, m_msgr});
                check("msg_active", {31'd0, act}, {31'd0, m_act});
                if (!synced) begin
                    if (ch == 4'b1110) begin
                        synced = 1; run_ch = ch; run_len = 1; run_seg = sg; seg_bad = 0;
                    end
                end else if (ch == run_ch) begin
                    run_len++;
                    if (sg != run_seg) seg_bad = 1;
                end else begin
                    close_run();
                    run_ch = ch; run_len = 1; run_seg = sg; seg_bad = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kb_send(input logic [7:0] c, input logic bk);
        int n = 0;
        @(negedge clk);
        bus.i_kb_valid = 1'b1; bus.i_kb_char = c; bus.i_kb_bksp = bk;
        while (!bus.o_kb_ready && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_note("kb_accept_timeout", n);
        @(negedge clk);
        bus.i_kb_valid = 1'b0; bus.i_kb_char = 8'($urandom); bus.i_kb_bksp = 1'($urandom);
    endtask

    task automatic msg_send(input logic [31:0] f);
        int n = 0;
        @(negedge clk);
        bus.i_msg_valid = 1'b1; bus.i_msg_frame = f;
        while (!bus.o_msg_ready && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_note("msg_accept_timeout", n);
        @(negedge clk);
        bus.i_msg_valid = 1'b0; bus.i_msg_frame = $urandom;
    endtask

    task automatic both_send(input logic [7:0] c, input logic [31:0] f);
        int n = 0;
        @(negedge clk);
        while (!(bus.o_msg_ready && bus.o_kb_ready) && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_note("both_accept_timeout", n);
        bus.i_kb_valid = 1'b1; bus.i_kb_char = c; bus.i_kb_bksp = 1'b0;
        bus.i_msg_valid = 1'b1; bus.i_msg_frame = f;
        @(negedge clk);
        bus.i_kb_valid = 1'b0; bus.i_msg_valid = 1'b0;
    endtask

    task automatic wait_inactive();
        int n = 0;
        while (act && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_note("msg_expiry_timeout", n);
    endtask

    initial begin
        int n, bad;
        bus.i_kb_valid = 0; bus.i_kb_char = 0; bus.i_kb_bksp = 0;
        bus.i_msg_valid = 0; bus.i_msg_frame = 0;
        bus_lk.i_kb_valid = 0; bus_lk.i_kb_char = 0; bus_lk.i_kb_bksp = 0;
        bus_lk.i_msg_valid = 0; bus_lk.i_msg_frame = 0;

        // Reset held: everything dark, no readies
        idle(4);
        check("rst_chosen", {28'd0, ch}, 32'hF);
        check("rst_segs", {24'd0, sg}, 32'hFF);
        check("rst_kb_ready", {31'd0, bus.o_kb_ready}, 32'd0);
        check("rst_msg_ready", {31'd0, bus.o_msg_ready}, 32'd0);
        check("rst_active", {31'd0, act}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_kb_ready", {31'd0, bus.o_kb_ready}, 32'd1);
        check("rel_msg_ready", {31'd0, bus.o_msg_ready}, 32'd1);

        // Directed sequence
        kb_send(8'hF9, 1'b0);
        kb_send(8'hA4, 1'b0);
        idle(2 * FRAME);
        kb_send(8'($urandom), 1'b1);
        idle(2 * FRAME);
        msg_send(32'h8688AFAF);
        check("msg_active_after_accept", {31'd0, act}, 32'd1);
        check("msg_ready_after_accept", {31'd0, bus.o_msg_ready}, 32'd0);
        wait_inactive();
        idle(FRAME);
        both_send(8'hC0, 32'h12345678);
        wait_inactive();
        idle(FRAME);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: kb_send(8'($urandom), 1'b0);
                4, 5:       kb_send(8'($urandom), 1'b1);
                6:          msg_send($urandom);
                7:          both_send(8'($urandom), $urandom);
                default:    idle($urandom_range(1, 40));
            endcase
        end
        wait_inactive();
        idle(2 * FRAME);

        // Keyboard lock variant: kb_ready stays low for the whole hold
        @(negedge clk);
        check("lock_kb_ready_idle", {31'd0, bus_lk.o_kb_ready}, 32'd1);
        bus_lk.i_msg_valid = 1'b1; bus_lk.i_msg_frame = 32'hC0F9A4B0;
        n = 0;
        while (!bus_lk.o_msg_ready && n < BUDGET) begin @(negedge clk); n++; end
        @(negedge clk);
        bus_lk.i_msg_valid = 1'b0;
        n = 0; bad = 0;
        while (act_lk && n < BUDGET) begin
            if (bus_lk.o_kb_ready) bad++;
            @(negedge clk);
            n++;
        end
        check("lock_kb_ready_low", bad, 32'd0);
        check("lock_hold_len_in_range",
              {31'd0, (n >= HOLD * FRAME - 1) && (n <= (HOLD + 1) * FRAME)}, 32'd1);
        check("lock_kb_ready_after", {31'd0, bus_lk.o_kb_ready}, 32'd1);

        // Reset in the middle of a lit slot while a message is shown
        msg_send($urandom);
        n = 0;
        while ((ch == 4'b1111 || !act) && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_note("midshow_wait_timeout", n);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_chosen", {28'd0, ch}, 32'hF);
        check("midrst_segs", {24'd0, sg}, 32'hFF);
        check("midrst_active", {31'd0, act}, 32'd0);
        check("midrst_msg_ready", {31'd0, bus.o_msg_ready}, 32'd0);
        check("midrst_kb_ready", {31'd0, bus.o_kb_ready}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_active", {31'd0, act}, 32'd0);
        idle(3 * FRAME);
        kb_send(8'($urandom), 1'b0);
        idle(3 * FRAME);

        check("frames_seen_enough", {31'd0, frames_seen >= 20}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
